// File: rtl/mult_pkg.sv
// Shared types for the repeated-addition multiplier: controller state encoding
// and the datapath width.
package mult_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        ADD    = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_e;

endpackage

// File: rtl/mult_rep_add_ctrl.sv
// Control FSM for the repeated-addition multiplier: captures A then B from the
// shared bus, strobes P <= P + A / B-- until eqz, with abort and a watchdog.
module mult_rep_add_ctrl
    import mult_pkg::*;
#(
    parameter int           W        = DATA_W,
    parameter logic [W-1:0] MAX_ITER = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         in_valid,
    input  logic         eqz,
    output logic         in_ready,
    output logic         LdA,
    output logic         LdB,
    output logic         LdP,
    output logic         clrP,
    output logic         decB,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] iter_cnt
);

    state_e       state_q, state_d;
    logic [W-1:0] iter_cnt_q, iter_cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            iter_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        in_ready   = 1'b0;
        LdA        = 1'b0;
        LdB        = 1'b0;
        LdP        = 1'b0;
        clrP       = 1'b0;
        decB       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOAD_A;
                    iter_cnt_d = '0;
                end
            end
            LOAD_A: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                LdA      = in_valid;
                if (in_valid) state_d = LOAD_B;
            end
            LOAD_B: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                LdB      = in_valid;
                clrP     = in_valid;
                if (in_valid) state_d = ADD;
            end
            ADD: begin
                busy = 1'b1;
                // eqz is checked first so B=0 never adds and B never wraps
                if (eqz) begin
                    state_d = DONE;
                end else if (iter_cnt_q < MAX_ITER) begin
                    LdP        = 1'b1;
                    decB       = 1'b1;
                    iter_cnt_d = iter_cnt_q + W'(1);
                end else begin
                    state_d = ERR;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            ERR: begin
                err = 1'b1;
                if (start) begin
                    state_d    = LOAD_A;
                    iter_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides everything except in IDLE, where start must win
        if (abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            iter_cnt_d = iter_cnt_q;
            in_ready   = 1'b0;
            LdA        = 1'b0;
            LdB        = 1'b0;
            LdP        = 1'b0;
            clrP       = 1'b0;
            decB       = 1'b0;
            done       = 1'b0;
        end
    end

    assign iter_cnt = iter_cnt_q;

endmodule

// File: tb/tb_mult_rep_add_ctrl.sv
// Directed bench for mult_rep_add_ctrl with a behavioural A/B/P datapath model;
// watchdog limit is set to 4 so the ERR path is reachable with small operands.
module tb_mult_rep_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n, start, abort, in_valid, eqz;
    logic         in_ready, LdA, LdB, LdP, clrP, decB, busy, done, err;
    logic [W-1:0] iter_cnt;
    logic [15:0]  data_in = '0;
    logic [15:0]  a_reg = '0, b_reg = '0, p_reg = '0;

    int errors = 0;
    int checks = 0;

    int r_ldp, r_done;
    bit r_gap_ok, r_load_ok;

    always #5 clk = ~clk;

    mult_rep_add_ctrl #(.W(W), .MAX_ITER(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .in_valid(in_valid), .eqz(eqz), .in_ready(in_ready),
        .LdA(LdA), .LdB(LdB), .LdP(LdP), .clrP(clrP), .decB(decB),
        .busy(busy), .done(done), .err(err), .iter_cnt(iter_cnt)
    );

    assign eqz = (b_reg == 16'd0);

    always @(posedge clk) begin
        if (LdA) a_reg <= data_in;
        if (LdB) b_reg <= data_in;
        else if (decB) b_reg <= b_reg - 16'd1;
        if (clrP) p_reg <= '0;
        else if (LdP) p_reg <= p_reg + a_reg;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic load_operands(input logic [15:0] a, input logic [15:0] b);
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        data_in = a;
        step();
        data_in = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_mult(input logic [15:0] a, input logic [15:0] b,
                            input int a_gap, input int b_gap);
        int cyc;
        r_ldp = 0; r_done = -1; r_gap_ok = 1'b1; r_load_ok = 1'b1;
        start = 1'b1; abort = 1'b0; in_valid = 1'b0;
        step();
        start = 1'b0;
        cyc = 1;
        repeat (a_gap) begin
            in_valid = 1'b0; #1;
            if (!(in_ready === 1'b1 && LdA === 1'b0 && busy === 1'b1)) r_gap_ok = 1'b0;
            step(); cyc++;
        end
        in_valid = 1'b1; data_in = a; #1;
        if (!(in_ready === 1'b1 && LdA === 1'b1 && LdB === 1'b0 && clrP === 1'b0)) r_load_ok = 1'b0;
        step(); cyc++;
        repeat (b_gap) begin
            in_valid = 1'b0; #1;
            if (!(in_ready === 1'b1 && LdB === 1'b0 && clrP === 1'b0)) r_gap_ok = 1'b0;
            step(); cyc++;
        end
        in_valid = 1'b1; data_in = b; #1;
        if (!(in_ready === 1'b1 && LdB === 1'b1 && clrP === 1'b1 && LdA === 1'b0)) r_load_ok = 1'b0;
        step(); cyc++;
        in_valid = 1'b0;
        for (int n = 0; n < 40; n++) begin
            #1;
            if (LdP === 1'b1) r_ldp++;
            if (done === 1'b1) begin
                r_done = cyc;
                step();
                break;
            end
            step(); cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        step(); step();
        rst_n = 1'b1; #1;
        checks++;
        if ({in_ready, LdA, LdB, LdP, clrP, decB, busy, done, err} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b expected %b",
                     {in_ready, LdA, LdB, LdP, clrP, decB, busy, done, err}, 9'b0);
        end
        checks++;
        if (iter_cnt !== 16'd0) begin
            errors++; $display("[TB] FAIL reset_iter: got %0d expected 0", iter_cnt);
        end
    endtask

    task automatic test_multiply();
        run_mult(16'd5, 16'd3, 0, 0);
        checks++;
        if (r_load_ok !== 1'b1) begin errors++; $display("[TB] FAIL mul5x3_load: got %0d expected 1", r_load_ok); end
        checks++;
        if (r_ldp != 3) begin errors++; $display("[TB] FAIL mul5x3_ldp: got %0d expected 3", r_ldp); end
        checks++;
        if (r_done != 7) begin errors++; $display("[TB] FAIL mul5x3_done_cycle: got %0d expected 7", r_done); end
        checks++;
        if (p_reg !== 16'd15) begin errors++; $display("[TB] FAIL mul5x3_p: got %0d expected 15", p_reg); end
        checks++;
        if (iter_cnt !== 16'd3) begin errors++; $display("[TB] FAIL mul5x3_iter: got %0d expected 3", iter_cnt); end
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL mul5x3_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_zero();
        run_mult(16'd7, 16'd0, 0, 0);
        checks++;
        if (r_ldp != 0) begin errors++; $display("[TB] FAIL mul7x0_ldp: got %0d expected 0", r_ldp); end
        checks++;
        if (r_done != 4) begin errors++; $display("[TB] FAIL mul7x0_done_cycle: got %0d expected 4", r_done); end
        checks++;
        if (p_reg !== 16'd0) begin errors++; $display("[TB] FAIL mul7x0_p: got %0d expected 0", p_reg); end
        checks++;
        if (iter_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mul7x0_iter: got %0d expected 0", iter_cnt); end
        run_mult(16'd0, 16'd4, 0, 0);
        checks++;
        if (r_ldp != 4) begin errors++; $display("[TB] FAIL mul0x4_ldp: got %0d expected 4", r_ldp); end
        checks++;
        if (r_done != 8) begin errors++; $display("[TB] FAIL mul0x4_done_cycle: got %0d expected 8", r_done); end
        checks++;
        if (p_reg !== 16'd0) begin errors++; $display("[TB] FAIL mul0x4_p: got %0d expected 0", p_reg); end
        checks++;
        if (iter_cnt !== 16'd4) begin errors++; $display("[TB] FAIL mul0x4_iter: got %0d expected 4", iter_cnt); end
    endtask

    task automatic test_gaps();
        run_mult(16'd6, 16'd3, 3, 2);
        checks++;
        if (r_gap_ok !== 1'b1) begin errors++; $display("[TB] FAIL gap_wait: got %0d expected 1", r_gap_ok); end
        checks++;
        if (r_load_ok !== 1'b1) begin errors++; $display("[TB] FAIL gap_load: got %0d expected 1", r_load_ok); end
        checks++;
        if (r_done != 12) begin errors++; $display("[TB] FAIL gap_done_cycle: got %0d expected 12", r_done); end
        checks++;
        if (p_reg !== 16'd18) begin errors++; $display("[TB] FAIL gap_p: got %0d expected 18", p_reg); end
    endtask

    task automatic test_abort();
        load_operands(16'd9, 16'd10);
        repeat (4) step();
        #1;
        checks++;
        if (iter_cnt !== 16'd4) begin errors++; $display("[TB] FAIL abort_pre_iter: got %0d expected 4", iter_cnt); end
        abort = 1'b1; #1;
        checks++;
        if (LdP !== 1'b0 || decB !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_strobes: got LdP=%b decB=%b done=%b expected 0 0 0", LdP, decB, done);
        end
        step();
        abort = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_idle: got busy=%b err=%b done=%b rdy=%b expected 0 0 0 0",
                               busy, err, done, in_ready);
        end
        checks++;
        if (iter_cnt !== 16'd4) begin errors++; $display("[TB] FAIL abort_iter: got %0d expected 4", iter_cnt); end
        checks++;
        if (p_reg !== 16'd36) begin errors++; $display("[TB] FAIL abort_p_kept: got %0d expected 36", p_reg); end
        run_mult(16'd3, 16'd2, 0, 0);
        checks++;
        if (r_done != 6 || p_reg !== 16'd6 || iter_cnt !== 16'd2) begin
            errors++; $display("[TB] FAIL abort_restart: got done=%0d p=%0d iter=%0d expected 6 6 2", r_done, p_reg, iter_cnt);
        end

        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; data_in = 16'd11; step();
        data_in = 16'd12; abort = 1'b1; #1;
        checks++;
        if (LdB !== 1'b0 || clrP !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_loadb_strobes: got LdB=%b clrP=%b expected 0 0", LdB, clrP);
        end
        step();
        abort = 1'b0; in_valid = 1'b0; #1;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_loadb_idle: got busy=%b rdy=%b expected 0 0", busy, in_ready);
        end

        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0; #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL start_beats_abort: got rdy=%b busy=%b expected 1 1", in_ready, busy);
        end
        abort = 1'b1; step(); abort = 1'b0;
    endtask

    task automatic test_watchdog();
        int ldp_n;
        bit seen;
        ldp_n = 0; seen = 1'b0;
        load_operands(16'd5, 16'd10);
        for (int n = 0; n < 30; n++) begin
            #1;
            if (LdP === 1'b1) ldp_n++;
            if (err === 1'b1) begin seen = 1'b1; break; end
            step();
        end
        checks++;
        if (seen !== 1'b1) begin errors++; $display("[TB] FAIL wd_err_seen: got %0d expected 1", seen); end
        checks++;
        if (ldp_n != 4) begin errors++; $display("[TB] FAIL wd_ldp: got %0d expected 4", ldp_n); end
        checks++;
        if (busy !== 1'b0 || iter_cnt !== 16'd4 || p_reg !== 16'd20) begin
            errors++; $display("[TB] FAIL wd_state: got busy=%b iter=%0d p=%0d expected 0 4 20", busy, iter_cnt, p_reg);
        end
        step(); #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("[TB] FAIL wd_err_held: got %b expected 1", err); end
        run_mult(16'd2, 16'd2, 0, 0);
        checks++;
        if (r_load_ok !== 1'b1 || r_done != 6 || p_reg !== 16'd4 || err !== 1'b0) begin
            errors++; $display("[TB] FAIL wd_restart: got load=%0d done=%0d p=%0d err=%b expected 1 6 4 0",
                               r_load_ok, r_done, p_reg, err);
        end
    endtask

    task automatic test_reset_mid_add();
        load_operands(16'd5, 16'd10);
        repeat (2) step();
        rst_n = 1'b0; step(); rst_n = 1'b1; #1;
        checks++;
        if ({in_ready, LdA, LdB, LdP, clrP, decB, busy, done, err} !== 9'b0 || iter_cnt !== 16'd0) begin
            errors++; $display("[TB] FAIL midreset_outputs: got %b iter=%0d expected %b iter=0",
                               {in_ready, LdA, LdB, LdP, clrP, decB, busy, done, err}, iter_cnt, 9'b0);
        end
        run_mult(16'd4, 16'd3, 0, 0);
        checks++;
        if (r_done != 7 || p_reg !== 16'd12 || iter_cnt !== 16'd3) begin
            errors++; $display("[TB] FAIL midreset_restart: got done=%0d p=%0d iter=%0d expected 7 12 3", r_done, p_reg, iter_cnt);
        end
    endtask

    task automatic test_back_to_back();
        run_mult(16'd3, 16'd4, 0, 0);
        checks++;
        if (r_done != 8 || p_reg !== 16'd12) begin
            errors++; $display("[TB] FAIL b2b_first: got done=%0d p=%0d expected 8 12", r_done, p_reg);
        end
        run_mult(16'd9, 16'd1, 0, 0);
        checks++;
        if (r_done != 5 || p_reg !== 16'd9 || iter_cnt !== 16'd1) begin
            errors++; $display("[TB] FAIL b2b_second: got done=%0d p=%0d iter=%0d expected 5 9 1", r_done, p_reg, iter_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_multiply();
        test_zero();
        test_gaps();
        test_abort();
        test_watchdog();
        test_reset_mid_add();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
